bucket_serializer: RTL and testbench

Write-side counterpart to the sorter. Accepts up to DEPTH bytes through a simple write port and tags each byte on write with one of four categories: even and divisible by 6, other even, odd and divisible by 3, other odd. On `start` it emits the stored bytes as one stream over a valid/ready handshake, grouped by category in fixed order. This block is the single-stream producer that a consumer can split back into buckets.

---
 rtl/bucket_serializer_pkg.sv | 18 +
 rtl/bucket_classify.sv | 27 ++
 rtl/bucket_serializer.sv | 129 ++++++++++++
 tb/tb_bucket_serializer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bucket_serializer_pkg.sv
// Shared definitions for the bucket serializer and its companion sorter bench.
//   CAT_*   : 2-bit category codes attached to every stored byte.
//   state_t : controller states (LOAD, SCAN, HOLD, DONE).
package bucket_serializer_pkg;

  localparam logic [1:0] CAT_DIV6 = 2'd0;  // even and divisible by 6 (includes 0)
  localparam logic [1:0] CAT_EVEN = 2'd1;  // other even
  localparam logic [1:0] CAT_DIV3 = 2'd2;  // odd and divisible by 3
  localparam logic [1:0] CAT_ODD  = 2'd3;  // other odd

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bucket_classify.sv
// Combinational category classifier for one unsigned W-bit value.
//   value : unsigned input value
//   cat   : category code (CAT_DIV6 / CAT_EVEN / CAT_DIV3 / CAT_ODD)
module bucket_classify
  import bucket_serializer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         unused_tie,
  output logic [1:0]   cat
);

  logic div3;

  // An even value divisible by 3 is exactly an even value divisible by 6,
  // so one modulo-3 test serves both parities.
  always_comb begin
    div3 = ((value % W'(3)) == '0);
    if (value[0]) cat = div3 ? CAT_DIV3 : CAT_ODD;
    else          cat = div3 ? CAT_DIV6 : CAT_EVEN;
  end

  logic unused_ok;
  assign unused_ok = unused_tie;

endmodule

// File: rtl/bucket_serializer.sv
// Buffers up to DEPTH bytes, tags each with a category on write, and on
// start emits them as one valid/ready stream grouped by category (0..3),
// preserving write order within each category.
//   clk, reset          : clock, asynchronous active-high reset
//   wr_en, wr_data      : write port; wr_full high when DEPTH entries held
//   start               : one-cycle pulse starting emission
//   busy                : high outside LOAD
//   out_valid/out_ready : output handshake carrying out_data/out_cat
//   done                : one-cycle pulse after emission ends
module bucket_serializer
  import bucket_serializer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         wr_full,
  input  logic         start,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_cat,
  output logic         done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t          state;
  logic [CW-1:0]   count;
  logic [AW-1:0]   slot_ptr;
  logic [1:0]      cat_ptr;
  logic [W+1:0]    mem [DEPTH];   // {data, category}

  logic [1:0]      wr_cat;
  logic            wr_accept;
  logic [W+1:0]    rd_entry;
  logic            hit;
  logic            last_slot;
  logic            last_pos;
  logic [AW-1:0]   nxt_slot;
  logic [1:0]      nxt_cat;

  bucket_classify #(.W(W)) u_classify (
    .value      (wr_data),
    .unused_tie (1'b0),
    .cat        (wr_cat)
  );

  assign wr_full   = (count == CW'(DEPTH));
  assign busy      = (state != LOAD);
  assign done      = (state == DONE);
  assign wr_accept = (state == LOAD) && wr_en && !wr_full;

  assign rd_entry  = mem[slot_ptr];
  assign hit       = (rd_entry[1:0] == cat_ptr);
  assign last_slot = ({1'b0, slot_ptr} == (count - CW'(1)));
  assign last_pos  = last_slot && (cat_ptr == CAT_ODD);

  // Pointer advance: wrap slot and step category at the last stored slot.
  // Never applied at the last position, so cat_ptr cannot wrap past 3.
  assign nxt_slot  = last_slot ? '0 : slot_ptr + AW'(1);
  assign nxt_cat   = last_slot ? cat_ptr + 2'd1 : cat_ptr;

  // Storage: no reset, contents survive emission and reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[count[AW-1:0]] <= {wr_data, wr_cat};
  end

  // Controller and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      count     <= '0;
      slot_ptr  <= '0;
      cat_ptr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cat   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (wr_accept) count <= count + CW'(1);
          if (start) begin
            slot_ptr <= '0;
            cat_ptr  <= '0;
            // A write accepted in the same cycle counts toward the emission.
            state    <= ((count != '0) || wr_accept) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (hit) begin
            out_data  <= rd_entry[W+1:2];
            out_cat   <= rd_entry[1:0];
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (last_pos) begin
            state <= DONE;
          end else begin
            slot_ptr <= nxt_slot;
            cat_ptr  <= nxt_cat;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_pos) begin
              state <= DONE;
            end else begin
              slot_ptr <= nxt_slot;
              cat_ptr  <= nxt_cat;
              state    <= SCAN;
            end
          end
        end
        DONE: begin
          count <= '0;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bucket_serializer.sv
// Scoreboard bench for bucket_serializer: a reference model of the buffer
// builds the expected stream at start; the monitor pops and compares each
// accepted item and checks handshake stability under backpressure.
module tb_bucket_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_full;
  logic       start = 1'b0;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_cat;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [8];
  int         model_cnt = 0;
  logic [9:0] exp_q [$];   // {data, cat}

  bucket_serializer #(.DEPTH(8), .W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cat   (out_cat),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_cat(input logic [7:0] v);
    int iv;
    iv = int'(v);
    if (iv % 2 == 0) return (iv % 6 == 0) ? 2'd0 : 2'd1;
    return (iv % 3 == 0) ? 2'd2 : 2'd3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
    if (model_cnt < 8) begin
      model_mem[model_cnt] = b;
      model_cnt++;
    end
  endtask

  task automatic build_expected();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < model_cnt; i++)
        if (ref_cat(model_mem[i]) == 2'(c)) exp_q.push_back({model_mem[i], 2'(c)});
    model_cnt = 0;
  endtask

  task automatic do_start();
    build_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor one emission until done; optional random backpressure and
  // optional injection of wr_en/start while busy.
  task automatic emit(input string name, input bit rnd_ready, input bit inject, input int budget);
    bit got_done = 1'b0;
    bit stalled = 1'b0;
    logic [7:0] hd = '0;
    logic [1:0] hc = '0;
    logic [9:0] e;
    for (int c = 0; c < budget && !got_done; c++) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && c == 1) begin wr_en = 1'b1; wr_data = 8'd9; start = 1'b1; end
      if (inject && c == 2) begin wr_en = 1'b0; start = 1'b0; end
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (stalled) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== hd || out_cat !== hc) begin
            errors++;
            $display("FAIL %s stall_hold: got v=%0b d=%0d c=%0d, need v=1 d=%0d c=%0d",
                     name, out_valid, out_data, out_cat, hd, hc);
          end
        end
        if (out_valid) begin
          if (out_ready) begin
            stalled = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL %s extra_item: got d=%0d c=%0d, need none", name, out_data, out_cat);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e[9:2] || out_cat !== e[1:0]) begin
                errors++;
                $display("FAIL %s item: got d=%0d c=%0d, need d=%0d c=%0d",
                         name, out_data, out_cat, e[9:2], e[1:0]);
              end
            end
          end else begin
            stalled = 1'b1;
            hd = out_data;
            hc = out_cat;
          end
        end
      end
      if (!got_done) tick();
    end
    wr_en = 1'b0;
    start = 1'b0;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s done_timeout: got no done in %0d cycles, need done", name, budget);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_items: got %0d left over, need 0", name, exp_q.size());
    end
    exp_q.delete();
    tick();
    out_ready = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_full !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%0b busy=%0b full=%0b, need 0 0 0",
               name, done, busy, wr_full);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_cat !== 2'd0 ||
        done !== 1'b0 || busy !== 1'b0 || wr_full !== 1'b0) begin
      errors++;
      $display("FAIL %s: got v=%0b d=%0d c=%0d done=%0b busy=%0b full=%0b, need all 0",
               name, out_valid, out_data, out_cat, done, busy, wr_full);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    check_idle("reset_values");
    tick();
    reset = 1'b0;
    tick();
    check_idle("post_reset");
  endtask

  task automatic load_basic();
    logic [7:0] v [8] = '{8'd5, 8'd4, 8'd2, 8'd1, 8'd10, 8'd0, 8'd12, 8'd3};
    for (int i = 0; i < 8; i++) wr(v[i]);
  endtask

  task automatic test_basic();
    load_basic();
    do_start();
    emit("basic", 1'b0, 1'b0, 100);
  endtask

  task automatic test_full();
    for (int i = 1; i <= 9; i++) begin
      wr(8'(i));
      if (i == 7 || i == 8) begin
        checks++;
        if (wr_full !== (i == 8)) begin
          errors++;
          $display("FAIL full_flag_%0d: got %0b, need %0b", i, wr_full, (i == 8));
        end
      end
    end
    do_start();
    emit("full", 1'b0, 1'b0, 100);
  endtask

  task automatic test_empty_start();
    bit got = 1'b0;
    do_start();
    for (int c = 0; c < 4 && !got; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_valid: got %0b, need 0", out_valid);
      end
      if (done) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL empty_done: got no done, need done pulse");
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got done=%0b busy=%0b, need 0 0", done, busy);
    end
  endtask

  task automatic test_same_cycle();
    model_mem[0] = 8'd7;
    model_cnt = 1;
    build_expected();
    wr_en = 1'b1;
    wr_data = 8'd7;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    emit("same_cycle", 1'b0, 1'b0, 50);
  endtask

  task automatic test_backpressure();
    load_basic();
    do_start();
    emit("backpressure", 1'b1, 1'b0, 400);
  endtask

  task automatic test_reset_in_hold();
    bit seen = 1'b0;
    load_basic();
    do_start();
    out_ready = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hold_reach: got no out_valid, need out_valid");
    end
    reset = 1'b1;
    #1;
    check_idle("reset_in_hold");
    #2;
    reset = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    tick();
    wr(8'd6);
    do_start();
    emit("after_reset", 1'b0, 1'b0, 50);
  endtask

  task automatic test_ignore_busy();
    wr(8'd8);
    wr(8'd15);
    wr(8'd1);
    do_start();
    emit("ignore_busy", 1'b0, 1'b1, 100);
    wr(8'd11);
    wr(8'd18);
    do_start();
    emit("next_load", 1'b0, 1'b0, 100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_empty_start();
    test_same_cycle();
    test_backpressure();
    test_reset_in_hold();
    test_ignore_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
